// File: rtl/fc_neuron_seq_pkg.sv
// Shared types and width helpers for the fully-connected layer blocks.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fc_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counters always need at least one bit, even when clog2 would return 0.
  function automatic int clog2_min1(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic int acc_width(input int width, input int in);
    return 2 * width + clog2(in);
  endfunction

  function automatic int tree_width(input int width, input int lanes);
    return 2 * width + clog2(lanes);
  endfunction

endpackage

// File: rtl/fc_neuron_seq_if.sv
// Beat-input and result-output handshake bundle for fc_neuron_seq.
interface fc_neuron_seq_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 16,
  parameter int ACC_W = 23
);

  logic signed [WIDTH-1:0] x_in [LANES];
  logic signed [WIDTH-1:0] w_in [LANES];
  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] z;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output x_in, w_in, in_valid, out_ready,
    input  in_ready, z, out_valid
  );

  modport slave (
    input  x_in, w_in, in_valid, out_ready,
    output in_ready, z, out_valid
  );

endinterface

// File: rtl/fc_mac_tree.sv
// Two-stage pipelined multiply / adder tree: registered lane products, then a
// registered signed sum of all lanes, with a matching valid pipeline.
module fc_mac_tree
  import fc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  input  logic signed [WIDTH-1:0]                    x [LANES],
  input  logic signed [WIDTH-1:0]                    w [LANES],
  output logic                                       out_valid,
  output logic signed [tree_width(WIDTH, LANES)-1:0] sum
);

  localparam int PW = 2 * WIDTH;
  localparam int TW = tree_width(WIDTH, LANES);

  logic signed [PW-1:0] prod [LANES];
  logic                 prod_valid;
  logic signed [TW-1:0] sum_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      prod_valid <= in_valid;
      out_valid  <= prod_valid;
    end
  end

  // Data registers only load on valid stages; their contents are ignored otherwise.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        prod[i] <= PW'(x[i]) * PW'(w[i]);
      end
    end
    if (prod_valid) begin
      sum <= sum_c;
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + TW'(prod[i]);
    end
  end

endmodule

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed fully-connected neuron: streams IN elements in beats of LANES,
// accumulates tree sums and holds the result. Optional ReLU via `FC_RELU_EN.
module fc_neuron_seq
  import fc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int LANES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fc_neuron_seq_if.slave bus
);

  localparam int BEATS = IN / LANES;
  localparam int ACC_W = acc_width(WIDTH, IN);
  localparam int TW    = tree_width(WIDTH, LANES);
  localparam int CW    = clog2_min1(BEATS + 1);

  fc_state_t            state, state_next;
  logic [CW-1:0]        beat_cnt;
  logic [CW-1:0]        acc_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] z_next;
  logic signed [ACC_W-1:0] z_q;
  logic                 tree_valid;
  logic signed [TW-1:0] tree_sum;
  logic                 accept;
  logic                 last_beat;
  logic                 last_sum;

  fc_mac_tree #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .x         (bus.x_in),
    .w         (bus.w_in),
    .out_valid (tree_valid),
    .sum       (tree_sum)
  );

  // Gated by rst_n so the block refuses beats while reset is held.
  assign bus.in_ready = rst_n & ((state == IDLE) |
                                 ((state == ACCUM) & (beat_cnt < CW'(BEATS))));
  assign accept    = bus.in_valid & bus.in_ready;
  assign last_beat = accept & (beat_cnt == CW'(BEATS - 1));
  assign last_sum  = tree_valid & (acc_cnt == CW'(BEATS - 1));
  assign acc_sum   = acc + ACC_W'(tree_sum);

`ifdef FC_RELU_EN
  assign z_next = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
  assign z_next = acc_sum;
`endif

  assign bus.z = z_q;

  always_comb begin
    state_next    = state;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:  if (accept) state_next = last_beat ? DRAIN : ACCUM;
      ACCUM: if (last_beat) state_next = DRAIN;
      DRAIN: if (last_sum) state_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      acc_cnt  <= '0;
      acc      <= '0;
      z_q      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (tree_valid) begin
        acc     <= acc_sum;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (last_sum) begin
        z_q <= z_next;
      end
      // Output handshake returns everything to the IDLE condition.
      if ((state == DONE) && bus.out_ready) begin
        acc      <= '0;
        beat_cnt <= '0;
        acc_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Directed, table-driven bench for fc_neuron_seq with default parameters
// (8 beats of 16 lanes, 23-bit result); expectations follow `FC_RELU_EN.
module tb_fc_neuron_seq;

  localparam int WIDTH = 8;
  localparam int IN    = 128;
  localparam int LANES = 16;
  localparam int BEATS = IN / LANES;
  localparam int ACC_W = 23;

  typedef struct {
    string name;
    int    xv;
    int    wv;
    int    zRaw;
  } vec_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   bx [BEATS][LANES];
  int   bw [BEATS][LANES];
  vec_t vecs [9];

  fc_neuron_seq_if #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W)) bus ();

  fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint applyRelu(input longint v);
`ifdef FC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic fillUniform(input int xv, input int wv);
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        bx[b][l] = xv;
        bw[b][l] = wv;
      end
    end
  endtask

  // Feeds nBeats beats from bx/bw; returns just after the edge that took the last one.
  task automatic applyStimulus(input int nBeats, input bit bubbles);
    int  b;
    int  guard;
    bit  took;
    b     = 0;
    guard = 0;
    @(posedge clk); #1;
    while (b < nBeats) begin
      if (bubbles && ($urandom_range(0, 2) == 0)) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          bus.x_in[l] = 8'(bx[b][l]);
          bus.w_in[l] = 8'(bw[b][l]);
        end
      end
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (took) b++;
      guard++;
      if (guard > 200) begin
        checkOutput("beat_accept_timeout", guard, 0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency, hold behaviour, result and handshake.
  task automatic waitResult(input string name, input longint expZ, input int stall);
    int  n;
    bit  rdyLow;
    longint zHeld;
    n      = 1;
    rdyLow = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.out_valid || n >= 20) break;
      if (bus.in_ready) rdyLow = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, "_latency"}, n, 3);
    checkOutput({name, "_in_ready_drain"}, rdyLow, 1);
    checkOutput({name, "_z"}, bus.z, expZ);
    zHeld = bus.z;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput({name, "_stall_valid"}, bus.out_valid, 1);
      checkOutput({name, "_stall_z"}, bus.z, zHeld);
      checkOutput({name, "_stall_in_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput({name, "_in_ready_after"}, bus.in_ready, 1);
    checkOutput({name, "_out_valid_after"}, bus.out_valid, 0);
  endtask

  initial begin
    longint refSum;

    vecs[0] = '{"ones",      1,    1,     128};
    vecs[1] = '{"min_min",  -128, -128,   2097152};
    vecs[2] = '{"neg",       1,   -1,    -128};
    vecs[3] = '{"two_three", 2,    3,     768};
    vecs[4] = '{"max_min",   127, -128,  -2080768};
    vecs[5] = '{"negneg",   -1,   -1,     128};
    vecs[6] = '{"zero",      0,    5,     0};
    vecs[7] = '{"max_max",   127,  127,   2064512};
    vecs[8] = '{"mixed",    -7,    9,    -8064};

    compared      = 0;
    mismatched    = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      bus.x_in[l] = '0;
      bus.w_in[l] = '0;
    end

    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_in_ready", bus.in_ready, 1);
    checkOutput("post_reset_out_valid", bus.out_valid, 0);
    checkOutput("post_reset_z", bus.z, 0);

    for (int i = 0; i < 9; i++) begin
      fillUniform(vecs[i].xv, vecs[i].wv);
      applyStimulus(BEATS, 1'b0);
      waitResult(vecs[i].name, applyRelu(vecs[i].zRaw), 0);
    end

    for (int r = 0; r < 3; r++) begin
      refSum = 0;
      for (int b = 0; b < BEATS; b++) begin
        for (int l = 0; l < LANES; l++) begin
          bx[b][l] = int'($urandom_range(0, 255)) - 128;
          bw[b][l] = int'($urandom_range(0, 255)) - 128;
          refSum += longint'(bx[b][l]) * longint'(bw[b][l]);
        end
      end
      applyStimulus(BEATS, 1'b1);
      waitResult("random_bubbles", applyRelu(refSum), 0);
    end

    fillUniform(1, 1);
    applyStimulus(BEATS, 1'b0);
    waitResult("stall5", 128, 5);

    fillUniform(9, 9);
    applyStimulus(4, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_after_in_ready", bus.in_ready, 1);
    checkOutput("midreset_after_out_valid", bus.out_valid, 0);
    fillUniform(2, 3);
    applyStimulus(BEATS, 1'b0);
    waitResult("after_reset", 768, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
